// File: rtl/imm_pkg.sv
//------------------------------------------------------------------------------
// Package : imm_pkg
// Shared types and default widths for the immediate-extension pipe.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package imm_pkg;

   // Extension mode carried alongside each immediate
   typedef enum logic [1:0] {
      SEXT = 2'd0,   // sign-extend
      ZEXT = 2'd1,   // zero-extend
      BOFF = 2'd2,   // sign-extend then scale by 4 (branch word offset)
      UPPR = 2'd3    // immediate placed in the top bits
   } imm_mode_t;

   // Occupancy of the output/skid register pair
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_t;

   localparam int IMM_IN_W  = 15;
   localparam int IMM_OUT_W = 32;

endpackage : imm_pkg

`default_nettype wire

// File: rtl/imm_extend_core.sv
//------------------------------------------------------------------------------
// Module  : imm_extend_core
// Purely combinational immediate extender (imm, mode -> ext).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_extend_core
   import imm_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W
) (
   input  logic [IN_W-1:0]  imm_i,
   input  logic [1:0]       mode_i,
   output logic [OUT_W-1:0] ext_o
);

   logic [OUT_W-1:0] sext_w;
   logic [OUT_W-1:0] zext_w;
   logic [OUT_W-1:0] boff_w;
   logic [OUT_W-1:0] uppr_w;

   assign sext_w = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
   assign zext_w = {{(OUT_W-IN_W){1'b0}}, imm_i};
   // Upper bits shifted out of the sign-extended value are redundant sign copies
   assign boff_w = {sext_w[OUT_W-3:0], 2'b00};
   assign uppr_w = {imm_i, {(OUT_W-IN_W){1'b0}}};

   // Select the extension flavour requested by the mode field
   always_comb begin
      ext_o = sext_w;
      case (imm_mode_t'(mode_i))
         SEXT:    ext_o = sext_w;
         ZEXT:    ext_o = zext_w;
         BOFF:    ext_o = boff_w;
         UPPR:    ext_o = uppr_w;
         default: ext_o = sext_w;
      endcase
   end

endmodule : imm_extend_core

`default_nettype wire

// File: rtl/imm_extend_pipe.sv
//------------------------------------------------------------------------------
// Module  : imm_extend_pipe
// Valid/ready pipe stage that registers the extended immediate.
// Build option: IMM_EXTEND_SKID_EN adds a skid register so in_ready is
// registered and throughput is kept under backpressure; without it a single
// output register is used and in_ready = !out_valid || out_ready.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_extend_pipe
   import imm_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  imm,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] ext_imm
);

   // BOFF needs two spare bits above the immediate to stay meaningful
   if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_extend_pipe: OUT_W must be >= IN_W+2");
   end

   pipe_state_t      state_q, state_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] ext_w;
   logic             in_xfer_w;
   logic             out_xfer_w;

   // Extension happens on the input side so mode is captured at acceptance
   imm_extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .imm_i  (imm),
      .mode_i (mode),
      .ext_o  (ext_w)
   );

`ifdef IMM_EXTEND_SKID_EN
   logic [OUT_W-1:0] skid_q, skid_d;
   logic             in_ready_q;

   assign in_ready = in_ready_q;
`else
   // Holds in_ready low until the first clock edge after reset release
   logic             alive_q;

   assign in_ready = alive_q && (!out_valid_q || out_ready);
`endif

   assign in_xfer_w  = in_valid && in_ready;
   assign out_xfer_w = out_valid_q && out_ready;
   assign out_valid  = out_valid_q;
   assign ext_imm    = out_q;

   // Next-state and datapath steering for the output/skid registers
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
`ifdef IMM_EXTEND_SKID_EN
      skid_d  = skid_q;
`endif
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer_w) begin
               out_d   = ext_w;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
`ifdef IMM_EXTEND_SKID_EN
            if (in_xfer_w && out_xfer_w) begin
               out_d = ext_w;
            end else if (in_xfer_w) begin
               skid_d  = ext_w;
               state_d = ST_TWO;
            end else if (out_xfer_w) begin
               state_d = ST_EMPTY;
            end
`else
            // An accept in ONE implies the held result leaves the same cycle
            if (in_xfer_w) begin
               out_d = ext_w;
            end else if (out_xfer_w) begin
               state_d = ST_EMPTY;
            end
`endif
         end
         ST_TWO: begin
`ifdef IMM_EXTEND_SKID_EN
            if (out_xfer_w) begin
               out_d   = skid_q;
               state_d = ST_ONE;
            end
`else
            state_d = ST_EMPTY;
`endif
         end
         default: state_d = ST_EMPTY;
      endcase
      out_valid_d = (state_d != ST_EMPTY);
   end

   // State and data registers; reset discards anything held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         out_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef IMM_EXTEND_SKID_EN
         skid_q      <= '0;
         in_ready_q  <= 1'b0;
`else
         alive_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
`ifdef IMM_EXTEND_SKID_EN
         skid_q      <= skid_d;
         in_ready_q  <= (state_d != ST_TWO);
`else
         alive_q     <= 1'b1;
`endif
      end
   end

endmodule : imm_extend_pipe

`default_nettype wire
